// File: rtl/sensor_avg_alarm.sv
// rtl/sensor_avg_alarm.sv - windowed sensor average with peak tracking and hysteretic alarm
//
// Ports:
//   clk           single clock, rising edge
//   rst_n         asynchronous active-low reset
//   sample_in     raw unsigned 8-bit sample
//   sample_valid  one sample accepted per high cycle
//   clear         synchronous restart of filter, peak and alarm (beats sample_valid)
//   thr_hi        alarm assert threshold (avg_out > thr_hi qualifies)
//   thr_lo        alarm deassert threshold (avg_out < thr_lo qualifies)
//   avg_out       registered window average, held between pulses
//   avg_valid     one-cycle pulse marking a new avg_out
//   alarm         hysteretic over-threshold flag
//   peak_out      largest sample accepted since reset/clear
module sensor_avg_alarm #(
    parameter int WIN_LOG2 = 2,
    parameter int HOLD     = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] sample_in,
    input  logic       sample_valid,
    input  logic       clear,
    input  logic [7:0] thr_hi,
    input  logic [7:0] thr_lo,
    output logic [7:0] avg_out,
    output logic       avg_valid,
    output logic       alarm,
    output logic [7:0] peak_out
);

    localparam int DEPTH = 1 << WIN_LOG2;
    localparam int SUM_W = 8 + WIN_LOG2;

    typedef enum logic {FILL, RUN} fill_state_t;
    typedef enum logic {NORMAL, ALARM} alarm_state_t;

    fill_state_t         fill_state, fill_state_next;
    alarm_state_t        alarm_state, alarm_state_next;

    logic [7:0]          buffer [DEPTH];
    logic [WIN_LOG2-1:0] wptr;
    logic [WIN_LOG2-1:0] fill_cnt;
    logic [SUM_W-1:0]    sum;
    logic [SUM_W-1:0]    sum_next;
    logic [3:0]          hit_cnt, hit_cnt_next;
    logic [3:0]          hit_inc;
    logic                accept;
    logic                window_full;
    logic                qualify;

    // clear discards any sample presented in the same cycle
    assign accept      = sample_valid && !clear;
    // true when this accepted sample completes (or follows) a full window
    assign window_full = (fill_state == RUN) || (fill_cnt == WIN_LOG2'(DEPTH - 1));
    // the sum always holds exactly the window contents, so modular add/sub is exact
    assign sum_next    = sum + SUM_W'(sample_in) - SUM_W'(buffer[wptr]);

    // Datapath: buffer, running sum, pointers, average and peak
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) buffer[i] <= '0;
            sum       <= '0;
            wptr      <= '0;
            fill_cnt  <= '0;
            avg_out   <= '0;
            avg_valid <= 1'b0;
            peak_out  <= '0;
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) buffer[i] <= '0;
            sum       <= '0;
            wptr      <= '0;
            fill_cnt  <= '0;
            avg_valid <= 1'b0;
            peak_out  <= '0;
        end else begin
            avg_valid <= accept && window_full;
            if (accept) begin
                buffer[wptr] <= sample_in;
                sum          <= sum_next;
                wptr         <= wptr + 1'b1;
                if (fill_state == FILL) fill_cnt <= fill_cnt + 1'b1;
                if (sample_in > peak_out) peak_out <= sample_in;
                if (window_full) avg_out <= sum_next[SUM_W-1:WIN_LOG2];
            end
        end
    end

    // Fill FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fill_state <= FILL;
        else        fill_state <= fill_state_next;
    end

    always_comb begin
        fill_state_next = fill_state;
        if (clear) begin
            fill_state_next = FILL;
        end else if (accept && fill_state == FILL && fill_cnt == WIN_LOG2'(DEPTH - 1)) begin
            fill_state_next = RUN;
        end
    end

    // Alarm FSM: only avg_valid cycles are evaluated, using the registered average
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_state <= NORMAL;
            hit_cnt     <= '0;
        end else begin
            alarm_state <= alarm_state_next;
            hit_cnt     <= hit_cnt_next;
        end
    end

    assign hit_inc = hit_cnt + 4'd1;
    assign qualify = (alarm_state == NORMAL) ? (avg_out > thr_hi) : (avg_out < thr_lo);

    always_comb begin
        alarm_state_next = alarm_state;
        hit_cnt_next     = hit_cnt;
        if (clear) begin
            alarm_state_next = NORMAL;
            hit_cnt_next     = '0;
        end else if (avg_valid) begin
            if (!qualify) begin
                hit_cnt_next = '0;
            end else if (hit_inc == 4'(HOLD)) begin
                alarm_state_next = (alarm_state == NORMAL) ? ALARM : NORMAL;
                hit_cnt_next     = '0;
            end else begin
                hit_cnt_next = hit_inc;
            end
        end
    end

    assign alarm = (alarm_state == ALARM);

endmodule

// File: tb/tb_sensor_avg_alarm.sv
// tb/tb_sensor_avg_alarm.sv - scoreboard bench for sensor_avg_alarm (WIN_LOG2=2, HOLD=3)
module tb_sensor_avg_alarm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] sample_in;
    logic       sample_valid;
    logic       clear;
    logic [7:0] thr_hi;
    logic [7:0] thr_lo;
    logic [7:0] avg_out;
    logic       avg_valid;
    logic       alarm;
    logic [7:0] peak_out;

    sensor_avg_alarm #(.WIN_LOG2(2), .HOLD(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .clear        (clear),
        .thr_hi       (thr_hi),
        .thr_lo       (thr_lo),
        .avg_out      (avg_out),
        .avg_valid    (avg_valid),
        .alarm        (alarm),
        .peak_out     (peak_out)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int pulses = 0;

    // reference model: plain sliding window of the last four accepted samples
    int win_q[$];
    int exp_q[$];
    int n_acc   = 0;
    int peak_m  = 0;
    int last_avg = 0;

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic model_restart();
        win_q.delete();
        n_acc  = 0;
        peak_m = 0;
    endtask

    task automatic send(input int s);
        int total;
        sample_in    = 8'(s);
        sample_valid = 1'b1;
        win_q.push_back(s);
        if (win_q.size() > 4) void'(win_q.pop_front());
        n_acc++;
        if (s > peak_m) peak_m = s;
        if (n_acc >= 4) begin
            total = 0;
            foreach (win_q[i]) total += win_q[i];
            last_avg = total / 4;
            exp_q.push_back(last_avg);
        end
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_restart();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_avg_out"},   avg_out,   0);
        check({tag, "_avg_valid"}, avg_valid, 0);
        check({tag, "_alarm"},     alarm,     0);
        check({tag, "_peak_out"},  peak_out,  0);
    endtask

    // monitor: every pulse must be expected, and must carry the expected average
    always @(negedge clk) begin
        if (rst_n === 1'b1 && avg_valid === 1'b1) begin
            pulses++;
            check("pulse_expected", int'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("avg_value", avg_out, exp_q.pop_front());
        end
    end

    initial begin
        int p0;
        rst_n = 1'b0; sample_in = '0; sample_valid = 1'b0; clear = 1'b0;
        thr_hi = 8'd100; thr_lo = 8'd50;
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // back-to-back fill: pulses only for 40 (avg 25) and 50 (avg 35)
        p0 = pulses;
        send(10); send(20); send(30); send(40); send(50);
        idle(2);
        check("fill_pulses", pulses - p0, 2);
        check("fill_drained", exp_q.size(), 0);
        check("fill_avg_held", avg_out, 35);
        check("fill_peak", peak_out, peak_m);

        // clear zeroes peak/alarm but holds avg_out
        do_clear();
        check("clear_peak", peak_out, 0);
        check("clear_avg_held", avg_out, last_avg);
        check("clear_alarm", alarm, 0);

        // truncation
        send(1); send(1); send(1); send(2);
        idle(2);
        check("trunc_avg", avg_out, 1);
        check("trunc_peak", peak_out, 2);
        check("trunc_drained", exp_q.size(), 0);

        // alarm assert after third qualifying average
        do_clear();
        repeat (5) send(200);
        send(200);                 // now in the 3rd avg_valid cycle
        check("alarm_before_rise", alarm, 0);
        @(negedge clk);
        check("alarm_rise", alarm, 1);
        // zeros: averages 150,100,50,0,0,0; 50 is not below thr_lo
        repeat (5) send(0);
        check("alarm_held_5th_zero", alarm, 1);
        send(0);
        check("alarm_held_6th_zero_cycle", alarm, 1);
        @(negedge clk);
        check("alarm_fall", alarm, 0);
        check("alarm_drained", exp_q.size(), 0);

        // re-raise alarm in RUN: averages 50,100,150,200,200
        repeat (5) send(200);
        @(negedge clk);
        check("alarm_rerise", alarm, 1);

        // clear beats a simultaneous sample
        clear = 1'b1; sample_in = 8'd99; sample_valid = 1'b1;
        @(negedge clk);
        clear = 1'b0; sample_valid = 1'b0;
        model_restart();
        check("clr_drop_peak", peak_out, 0);
        check("clr_drop_alarm", alarm, 0);
        check("clr_drop_valid", avg_valid, 0);
        p0 = pulses;
        send(4); send(4); send(4);
        idle(2);
        check("clr_no_early_pulse", pulses - p0, 0);
        send(8);
        idle(2);
        check("clr_refill_pulse", pulses - p0, 1);
        check("clr_refill_avg", avg_out, 5);
        check("clr_refill_peak", peak_out, 8);

        // asynchronous reset mid-fill discards partial data
        do_clear();
        send(7); send(7);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        model_restart();
        check("reset_no_pending", exp_q.size(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        p0 = pulses;
        repeat (4) send(8);
        idle(2);
        check("post_reset_pulses", pulses - p0, 1);
        check("post_reset_avg", avg_out, 8);
        check("post_reset_peak", peak_out, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
